// File: rtl/fir_pkg.sv
// Address map, ap_ctrl bit positions and sequencer state codes shared by the FIR control block.
package fir_pkg;

    localparam logic [11:0] ADDR_AP_CTRL  = 12'h000;
    localparam logic [11:0] ADDR_DATA_LEN = 12'h010;
    localparam logic [11:0] ADDR_TAP_NUM  = 12'h014;
    localparam logic [11:0] ADDR_TAP_BASE = 12'h080;

    localparam int AP_START_BIT = 0;
    localparam int AP_DONE_BIT  = 1;
    localparam int AP_IDLE_BIT  = 2;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

endpackage

// File: rtl/fir_ctrl_axil.sv
// AXI-Lite slave front end: independent AW/W holders producing a one-cycle commit strobe,
// and a single-outstanding read pipeline (latch address, RAM access, capture into rdata).
module fir_ctrl_axil
    import fir_pkg::*;
#(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   awvalid,
    output logic                   awready,
    input  logic [pADDR_WIDTH-1:0] awaddr,
    input  logic                   wvalid,
    output logic                   wready,
    input  logic [pDATA_WIDTH-1:0] wdata,
    input  logic                   arvalid,
    output logic                   arready,
    input  logic [pADDR_WIDTH-1:0] araddr,
    output logic                   rvalid,
    input  logic                   rready,
    output logic [pDATA_WIDTH-1:0] rdata,
    output logic                   wr_commit,
    output logic [pADDR_WIDTH-1:0] wr_addr,
    output logic [pDATA_WIDTH-1:0] wr_data,
    output logic                   rd_acc,
    output logic [pADDR_WIDTH-1:0] rd_addr,
    output logic                   rd_done,
    input  logic                   rd_stall,
    input  logic                   rd_use_ram,
    input  logic [pDATA_WIDTH-1:0] rd_reg_val,
    input  logic [pDATA_WIDTH-1:0] tap_do
);

    logic                   aw_held, w_held, rd_busy;
    logic                   aw_held_nx, w_held_nx, rd_busy_nx;
    logic                   ar_hs, r_hs, acc_go;
    logic                   cap_p2, use_ram_p2;
    logic [pDATA_WIDTH-1:0] snap_p2;

    assign wr_commit = aw_held & w_held;
    assign ar_hs     = arvalid & arready;
    assign r_hs      = rvalid & rready;
    assign acc_go    = rd_acc & ~rd_stall;
    assign rd_done   = r_hs;

    always_comb begin
        aw_held_nx = aw_held;
        w_held_nx  = w_held;
        rd_busy_nx = rd_busy;
        if (wr_commit) begin
            aw_held_nx = 1'b0;
            w_held_nx  = 1'b0;
        end else begin
            if (awvalid && awready) aw_held_nx = 1'b1;
            if (wvalid && wready)   w_held_nx  = 1'b1;
        end
        if (r_hs)       rd_busy_nx = 1'b0;
        else if (ar_hs) rd_busy_nx = 1'b1;
    end

    // Ready flags are registered copies of "holder empty" so they stay low during reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            rd_busy <= 1'b0;
            awready <= 1'b0;
            wready  <= 1'b0;
            arready <= 1'b0;
            rd_acc  <= 1'b0;
            cap_p2  <= 1'b0;
            rvalid  <= 1'b0;
            rdata   <= '0;
        end else begin
            aw_held <= aw_held_nx;
            w_held  <= w_held_nx;
            rd_busy <= rd_busy_nx;
            awready <= ~aw_held_nx;
            wready  <= ~w_held_nx;
            arready <= ~rd_busy_nx;
            // stage 1: RAM access, held over while a tap write owns the port
            if (ar_hs)       rd_acc <= 1'b1;
            else if (acc_go) rd_acc <= 1'b0;
            // stage 2: RAM data available, capture into rdata
            cap_p2 <= acc_go;
            if (cap_p2) begin
                rvalid <= 1'b1;
                rdata  <= use_ram_p2 ? tap_do : snap_p2;
            end else if (r_hs) begin
                rvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (awvalid && awready) wr_addr <= awaddr;
        if (wvalid && wready)   wr_data <= wdata;
        if (ar_hs)              rd_addr <= araddr;
        if (acc_go) begin
            use_ram_p2 <= rd_use_ram;
            snap_p2    <= rd_reg_val;
        end
    end

endmodule

// File: rtl/fir_ctrl.sv
// FIR accelerator control: config register file, IDLE/RUN/DONE sequencer counting output
// beats, and the tap RAM port mux between the AXI-Lite slave and the engine.
module fir_ctrl
    import fir_pkg::*;
#(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32,
    parameter int pTAP_MAX    = 32
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst_n,
    input  logic                   awvalid,
    output logic                   awready,
    input  logic [pADDR_WIDTH-1:0] awaddr,
    input  logic                   wvalid,
    output logic                   wready,
    input  logic [pDATA_WIDTH-1:0] wdata,
    input  logic                   arvalid,
    output logic                   arready,
    input  logic [pADDR_WIDTH-1:0] araddr,
    output logic                   rvalid,
    input  logic                   rready,
    output logic [pDATA_WIDTH-1:0] rdata,
    output logic [3:0]             tap_WE,
    output logic                   tap_EN,
    output logic [pDATA_WIDTH-1:0] tap_Di,
    output logic [pADDR_WIDTH-1:0] tap_A,
    input  logic [pDATA_WIDTH-1:0] tap_Do,
    input  logic                   eng_tap_EN,
    input  logic [pADDR_WIDTH-1:0] eng_tap_A,
    output logic                   eng_start,
    output logic [pDATA_WIDTH-1:0] cfg_data_len,
    output logic [pDATA_WIDTH-1:0] cfg_tap_num,
    input  logic                   sm_tvalid,
    input  logic                   sm_tready,
    input  logic                   sm_tlast
);

    localparam logic [pADDR_WIDTH-1:0] A_CTRL    = pADDR_WIDTH'(ADDR_AP_CTRL);
    localparam logic [pADDR_WIDTH-1:0] A_LEN     = pADDR_WIDTH'(ADDR_DATA_LEN);
    localparam logic [pADDR_WIDTH-1:0] A_TAPN    = pADDR_WIDTH'(ADDR_TAP_NUM);
    localparam logic [pADDR_WIDTH-1:0] A_TAPB    = pADDR_WIDTH'(ADDR_TAP_BASE);
    localparam logic [pADDR_WIDTH-1:0] A_TAP_END = A_TAPB + pADDR_WIDTH'(4 * pTAP_MAX);

    function automatic logic in_tap(input logic [pADDR_WIDTH-1:0] a);
        return (a >= A_TAPB) && (a < A_TAP_END);
    endfunction

    logic                   wr_commit, rd_acc, rd_done;
    logic [pADDR_WIDTH-1:0] wr_addr, rd_addr;
    logic [pDATA_WIDTH-1:0] wr_data, rd_reg_val;
    logic                   wr_tap, rd_tap, run, ram_wr, rd_stall, rd_use_ram;
    logic                   start_commit, beat, last_beat;

    logic [1:0]             state;
    logic                   ap_done, start_flag;
    logic [pDATA_WIDTH-1:0] data_len, tap_num, out_cnt;

    fir_ctrl_axil #(
        .pADDR_WIDTH (pADDR_WIDTH),
        .pDATA_WIDTH (pDATA_WIDTH)
    ) u_axil (
        .clk        (axis_clk),
        .rst_n      (axis_rst_n),
        .awvalid    (awvalid),
        .awready    (awready),
        .awaddr     (awaddr),
        .wvalid     (wvalid),
        .wready     (wready),
        .wdata      (wdata),
        .arvalid    (arvalid),
        .arready    (arready),
        .araddr     (araddr),
        .rvalid     (rvalid),
        .rready     (rready),
        .rdata      (rdata),
        .wr_commit  (wr_commit),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rd_acc     (rd_acc),
        .rd_addr    (rd_addr),
        .rd_done    (rd_done),
        .rd_stall   (rd_stall),
        .rd_use_ram (rd_use_ram),
        .rd_reg_val (rd_reg_val),
        .tap_do     (tap_Do)
    );

    assign run          = (state == RUN);
    assign wr_tap       = in_tap(wr_addr);
    assign rd_tap       = in_tap(rd_addr);
    assign ram_wr       = wr_commit & wr_tap & ~run;
    assign rd_stall     = ram_wr & rd_acc & rd_tap;
    assign rd_use_ram   = rd_tap & ~run;
    assign start_commit = wr_commit & ~run & (wr_addr == A_CTRL) & wr_data[AP_START_BIT];
    assign beat         = sm_tvalid & sm_tready;
    // Compare one bit wider so a full-scale data_length never wraps into a false match.
    assign last_beat    = ({1'b0, out_cnt} + (pDATA_WIDTH+1)'(1) == {1'b0, data_len})
                          | sm_tlast | (data_len == '0);

    assign cfg_data_len = data_len;
    assign cfg_tap_num  = tap_num;

    always_comb begin
        rd_reg_val = '0;
        if (rd_addr == A_CTRL) begin
            rd_reg_val[AP_IDLE_BIT]  = ~run;
            rd_reg_val[AP_DONE_BIT]  = ap_done;
            rd_reg_val[AP_START_BIT] = run & start_flag;
        end else if (rd_addr == A_LEN) begin
            rd_reg_val = data_len;
        end else if (rd_addr == A_TAPN) begin
            rd_reg_val = tap_num;
        end else if (rd_tap && run) begin
            rd_reg_val = '1;
        end
    end

    always_comb begin
        tap_EN = 1'b0;
        tap_WE = 4'h0;
        tap_A  = '0;
        tap_Di = '0;
        if (run) begin
            tap_EN = eng_tap_EN;
            tap_A  = eng_tap_A;
        end else if (ram_wr) begin
            tap_EN = 1'b1;
            tap_WE = 4'hF;
            tap_A  = wr_addr - A_TAPB;
            tap_Di = wr_data;
        end else if (rd_acc && rd_tap) begin
            tap_EN = 1'b1;
            tap_A  = rd_addr - A_TAPB;
        end
    end

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            state      <= IDLE;
            ap_done    <= 1'b0;
            start_flag <= 1'b0;
            eng_start  <= 1'b0;
            out_cnt    <= '0;
            data_len   <= '0;
            tap_num    <= '0;
        end else begin
            eng_start <= 1'b0;
            if (wr_commit && !run) begin
                if (wr_addr == A_LEN)  data_len <= wr_data;
                if (wr_addr == A_TAPN) tap_num  <= wr_data;
            end
            if (run) begin
                if (beat) begin
                    out_cnt    <= out_cnt + 1'b1;
                    start_flag <= 1'b0;
                    if (last_beat) begin
                        state   <= DONE;
                        ap_done <= 1'b1;
                    end
                end
            end else if (start_commit) begin
                state      <= RUN;
                eng_start  <= 1'b1;
                out_cnt    <= '0;
                ap_done    <= 1'b0;
                start_flag <= 1'b1;
            end else if (state == DONE && rd_done && rd_addr == A_CTRL) begin
                state   <= IDLE;
                ap_done <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fir_ctrl.sv
// Directed bench for fir_ctrl: AXI-Lite register/tap access, start/done sequencing and
// mid-run reset, against a behavioural 1-cycle-read tap RAM.
module tb_fir_ctrl;

    logic        axis_clk = 1'b0;
    logic        axis_rst_n;
    logic        awvalid, awready, wvalid, wready, arvalid, arready, rvalid, rready;
    logic [11:0] awaddr, araddr, tap_A, eng_tap_A;
    logic [31:0] wdata, rdata, tap_Di, tap_Do, cfg_data_len, cfg_tap_num;
    logic [3:0]  tap_WE;
    logic        tap_EN, eng_tap_EN, eng_start, sm_tvalid, sm_tready, sm_tlast;

    int errors = 0;
    int checks = 0;
    int we_cnt = 0;
    int start_cnt = 0;

    logic [31:0] ram [0:31];

    int coefs [20] = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0, 1, 2, 3, 4, 5, -6, -7, -8, 100};

    always #5 axis_clk = ~axis_clk;

    fir_ctrl dut (
        .axis_clk     (axis_clk),
        .axis_rst_n   (axis_rst_n),
        .awvalid      (awvalid),
        .awready      (awready),
        .awaddr       (awaddr),
        .wvalid       (wvalid),
        .wready       (wready),
        .wdata        (wdata),
        .arvalid      (arvalid),
        .arready      (arready),
        .araddr       (araddr),
        .rvalid       (rvalid),
        .rready       (rready),
        .rdata        (rdata),
        .tap_WE       (tap_WE),
        .tap_EN       (tap_EN),
        .tap_Di       (tap_Di),
        .tap_A        (tap_A),
        .tap_Do       (tap_Do),
        .eng_tap_EN   (eng_tap_EN),
        .eng_tap_A    (eng_tap_A),
        .eng_start    (eng_start),
        .cfg_data_len (cfg_data_len),
        .cfg_tap_num  (cfg_tap_num),
        .sm_tvalid    (sm_tvalid),
        .sm_tready    (sm_tready),
        .sm_tlast     (sm_tlast)
    );

    always @(posedge axis_clk) begin
        if (tap_EN) begin
            if (tap_WE == 4'hF) ram[tap_A[6:2]] <= tap_Di;
            tap_Do <= ram[tap_A[6:2]];
        end
    end

    always @(negedge axis_clk) begin
        if (tap_WE != 4'h0) we_cnt <= we_cnt + 1;
        if (eng_start)      start_cnt <= start_cnt + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic axi_write(input logic [11:0] a, input logic [31:0] d, input int mode);
        bit aw_done, w_done, hs_aw, hs_w;
        int n;
        aw_done = 0; w_done = 0; n = 0;
        if (mode != 1) begin awaddr = a; awvalid = 1'b1; end
        if (mode != 0) begin wdata = d; wvalid = 1'b1; end
        while (!(aw_done && w_done) && n < 50) begin
            @(negedge axis_clk);
            hs_aw = awvalid && awready;
            hs_w  = wvalid && wready;
            @(posedge axis_clk); #1;
            if (hs_aw) begin awvalid = 1'b0; aw_done = 1; end
            if (hs_w)  begin wvalid = 1'b0; w_done = 1; end
            if (mode == 0 && aw_done && !w_done && !wvalid) begin wdata = d; wvalid = 1'b1; end
            if (mode == 1 && w_done && !aw_done && !awvalid) begin awaddr = a; awvalid = 1'b1; end
            n++;
        end
        awvalid = 1'b0; wvalid = 1'b0;
        chk("write_handshake", 32'(aw_done && w_done), 32'd1);
        repeat (2) @(posedge axis_clk);
        #1;
    endtask

    task automatic axi_read(input logic [11:0] a, input int stall,
                            output logic [31:0] d, output int lat);
        bit hs, stable;
        int n;
        logic [31:0] first;
        araddr = a; arvalid = 1'b1; n = 0; hs = 0;
        while (!hs && n < 50) begin
            @(negedge axis_clk);
            hs = arready;
            @(posedge axis_clk); #1;
            n++;
        end
        arvalid = 1'b0;
        hs = 0; lat = 0;
        while (!hs && lat < 50) begin
            @(negedge axis_clk);
            lat++;
            hs = rvalid;
        end
        chk("read_response", 32'(hs), 32'd1);
        lat = lat - 1;
        first = rdata; stable = 1;
        repeat (stall) begin
            @(posedge axis_clk);
            @(negedge axis_clk);
            if (rdata !== first || !rvalid) stable = 0;
        end
        rready = 1'b1;
        @(posedge axis_clk); #1;
        rready = 1'b0;
        chk("rvalid_drop", 32'(rvalid), 32'd0);
        chk("rdata_stable", 32'(stable), 32'd1);
        d = first;
    endtask

    task automatic sm_beats(input int count, input bit last_on_final);
        int got, n;
        got = 0; n = 0;
        sm_tvalid = 1'b1;
        while (got < count && n < 300) begin
            sm_tready = ($urandom_range(0, 2) != 0);
            sm_tlast  = last_on_final && (got == count - 1);
            @(negedge axis_clk);
            if (sm_tready) got++;
            @(posedge axis_clk); #1;
            n++;
        end
        sm_tvalid = 1'b0; sm_tready = 1'b0; sm_tlast = 1'b0;
        chk("sm_beats", 32'(got), 32'(count));
    endtask

    initial begin
        logic [31:0] d;
        int lat, we0, st0;

        axis_rst_n = 1'b0;
        awvalid = 0; wvalid = 0; arvalid = 0; rready = 0;
        awaddr = '0; araddr = '0; wdata = '0;
        eng_tap_EN = 0; eng_tap_A = '0;
        sm_tvalid = 0; sm_tready = 0; sm_tlast = 0;

        // 1. reset state
        repeat (3) @(posedge axis_clk);
        @(negedge axis_clk);
        chk("rst_awready", 32'(awready), 32'd0);
        chk("rst_arready", 32'(arready), 32'd0);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_tap_en", 32'(tap_EN), 32'd0);
        chk("rst_eng_start", 32'(eng_start), 32'd0);
        chk("rst_data_len", cfg_data_len, 32'd0);
        @(posedge axis_clk); #1;
        axis_rst_n = 1'b1;
        repeat (2) @(posedge axis_clk);
        #1;
        axi_read(12'h000, 0, d, lat);
        chk("ctrl_idle", d, 32'h4);
        chk("read_latency", 32'(lat), 32'd2);
        axi_read(12'h010, 1, d, lat);
        chk("len_reset", d, 32'd0);

        // 2. write ordering variants
        we0 = we_cnt;
        for (int m = 0; m < 3; m++) begin
            axi_write(12'h010, 32'd400 + 32'(m), m);
            axi_read(12'h010, m, d, lat);
            chk("len_readback", d, 32'd400 + 32'(m));
        end
        chk("cfg_data_len", cfg_data_len, 32'd402);
        axi_write(12'h014, 32'd11, 2);
        chk("cfg_tap_num", cfg_tap_num, 32'd11);
        axi_write(12'h020, 32'h1234, 0);
        axi_read(12'h020, 0, d, lat);
        chk("unmapped_read", d, 32'd0);
        chk("reg_we_none", 32'(we_cnt - we0), 32'd0);

        // 3. tap writes and read-back with late rready
        we0 = we_cnt;
        for (int k = 0; k < 20; k++) axi_write(12'h080 + 12'(4 * k), 32'(coefs[k]), k % 3);
        chk("tap_we_pulses", 32'(we_cnt - we0), 32'd20);
        for (int k = 0; k < 20; k++) begin
            axi_read(12'h080 + 12'(4 * k), k % 4, d, lat);
            chk("tap_readback", d, 32'(coefs[k]));
        end

        // 4/5. run with data_len=5, AXI tap access blocked during RUN
        axi_write(12'h010, 32'd5, 2);
        st0 = start_cnt;
        axi_write(12'h000, 32'd1, 2);
        chk("eng_start_pulse", 32'(start_cnt - st0), 32'd1);
        axi_read(12'h000, 0, d, lat);
        chk("ctrl_running", d, 32'h1);
        we0 = we_cnt;
        axi_write(12'h080, 32'd99, 1);
        axi_write(12'h010, 32'd7, 0);
        axi_read(12'h084, 2, d, lat);
        chk("run_tap_read", d, 32'hFFFF_FFFF);
        chk("run_tap_we", 32'(we_cnt - we0), 32'd0);
        eng_tap_EN = 1'b1; eng_tap_A = 12'h008;
        @(posedge axis_clk); #1;
        eng_tap_EN = 1'b0;
        chk("engine_tap_read", tap_Do, 32'(coefs[2]));
        sm_beats(5, 0);
        axi_read(12'h080, 0, d, lat);
        chk("tap_kept", d, 32'(coefs[0]));
        axi_read(12'h010, 0, d, lat);
        chk("len_kept", d, 32'd5);
        axi_read(12'h000, 1, d, lat);
        chk("ctrl_done", d, 32'h6);
        axi_read(12'h000, 0, d, lat);
        chk("ctrl_idle_after", d, 32'h4);

        // 6. reset mid-run, then a data_len=0 run
        axi_write(12'h010, 32'd5, 0);
        axi_write(12'h000, 32'd1, 1);
        sm_beats(2, 0);
        axis_rst_n = 1'b0;
        @(negedge axis_clk);
        chk("midrst_len", cfg_data_len, 32'd0);
        @(posedge axis_clk); #1;
        axis_rst_n = 1'b1;
        repeat (2) @(posedge axis_clk);
        #1;
        axi_read(12'h000, 0, d, lat);
        chk("midrst_ctrl", d, 32'h4);
        axi_read(12'h010, 0, d, lat);
        chk("midrst_len_read", d, 32'd0);
        axi_read(12'h088, 0, d, lat);
        chk("midrst_ram", d, 32'(coefs[2]));
        st0 = start_cnt;
        axi_write(12'h000, 32'd1, 2);
        chk("restart_pulse", 32'(start_cnt - st0), 32'd1);
        sm_beats(1, 0);
        axi_read(12'h000, 0, d, lat);
        chk("len0_done", d, 32'h6);
        axi_read(12'h000, 0, d, lat);
        chk("len0_idle", d, 32'h4);

        // 7. early end on sm_tlast
        axi_write(12'h010, 32'd100, 1);
        axi_write(12'h000, 32'd1, 0);
        sm_beats(2, 0);
        axi_read(12'h000, 0, d, lat);
        chk("tlast_running", d, 32'h0);
        sm_beats(1, 1);
        axi_read(12'h000, 0, d, lat);
        chk("tlast_done", d, 32'h6);
        axi_read(12'h000, 0, d, lat);
        chk("tlast_idle", d, 32'h4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
